// File: rtl/sort_pkg.sv
// ---------------------------------------------------------------------------
// sort_pkg
// Shared definitions for the streaming sorter family.
//   sort_state_e   : control states (IDLE, SORT, DONE)
//   idx_w(n)       : width of a lane index for n lanes, never below 1
//   SORT_DEF_*     : default geometry used by the interface and the top
//   `SORT_LANE     : slice lane k (width w) out of a packed lane vector
// No ports; this file only provides types, constants and helpers.
// ---------------------------------------------------------------------------
`ifndef SORT_PKG_MACROS
`define SORT_PKG_MACROS
// Lane k of a packed vector; lane 0 sits in the least significant bits.
`define SORT_LANE(vec, k, w) vec[(k)*(w) +: (w)]
`endif

package sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } sort_state_e;

  localparam int SORT_DEF_NUM_VALS = 9;
  localparam int SORT_DEF_SIZE     = 8;

  // Bits needed to hold a lane number 0..n-1; a single-bit minimum keeps
  // vector declarations legal for degenerate lane counts.
  function automatic int idx_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sort_oet_stream_if.sv
// ---------------------------------------------------------------------------
// sort_oet_stream_if
// Handshake and data bundle between a vector producer/consumer and the
// odd-even transposition sorter.
//   in_valid/in_ready/in_data/in_desc : input vector channel
//   out_valid/out_ready/out_data      : sorted vector channel
//   out_idx                           : original lane of each output lane
//                                       (only when SORT_INDEX_EN is defined)
//   busy                              : sorter is running passes
// Modports: master (producer/consumer side), slave (sorter side).
// Optional feature macro: SORT_INDEX_EN.
// ---------------------------------------------------------------------------
interface sort_oet_stream_if
  import sort_pkg::*;
#(
  parameter int NUM_VALS = SORT_DEF_NUM_VALS,
  parameter int SIZE     = SORT_DEF_SIZE,
  parameter int IDX_W    = idx_w(NUM_VALS)
);

  logic                       in_valid;
  logic                       in_ready;
  logic [NUM_VALS*SIZE-1:0]   in_data;
  logic                       in_desc;
  logic                       out_valid;
  logic                       out_ready;
  logic [NUM_VALS*SIZE-1:0]   out_data;
`ifdef SORT_INDEX_EN
  logic [NUM_VALS*IDX_W-1:0]  out_idx;
`endif
  logic                       busy;

  modport master (
    output in_valid, in_data, in_desc, out_ready,
`ifdef SORT_INDEX_EN
    input  out_idx,
`endif
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_desc, out_ready,
`ifdef SORT_INDEX_EN
    output out_idx,
`endif
    output in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/sort_cmp_swap.sv
// ---------------------------------------------------------------------------
// sort_cmp_swap
// One compare-exchange cell for an adjacent lane pair (a = lower lane index,
// b = upper lane index). Purely combinational.
//   a, b           : lane values, unsigned
//   tag_a, tag_b   : lane tags (only when SORT_INDEX_EN is defined)
//   desc           : 1 -> larger value goes to the lower lane
//   lo, hi         : resulting lower-lane / upper-lane values
//   lo_tag, hi_tag : tags following their values (SORT_INDEX_EN only)
// The swap condition is strict so equal values never exchange, which keeps
// the overall sort stable.
// Optional feature macro: SORT_INDEX_EN.
// ---------------------------------------------------------------------------
module sort_cmp_swap #(
`ifdef SORT_INDEX_EN
  parameter int IDX_W = 1,
`endif
  parameter int SIZE  = 8
) (
  input  logic [SIZE-1:0]  a,
  input  logic [SIZE-1:0]  b,
`ifdef SORT_INDEX_EN
  input  logic [IDX_W-1:0] tag_a,
  input  logic [IDX_W-1:0] tag_b,
  output logic [IDX_W-1:0] lo_tag,
  output logic [IDX_W-1:0] hi_tag,
`endif
  input  logic             desc,
  output logic [SIZE-1:0]  lo,
  output logic [SIZE-1:0]  hi
);

  logic swap;

  assign swap = desc ? (b > a) : (b < a);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

`ifdef SORT_INDEX_EN
  assign lo_tag = swap ? tag_b : tag_a;
  assign hi_tag = swap ? tag_a : tag_b;
`endif

endmodule

// File: rtl/sort_oet_stream.sv
// ---------------------------------------------------------------------------
// sort_oet_stream
// Sequential odd-even transposition sorter. A whole vector of NUM_VALS
// unsigned SIZE-bit lanes is accepted in one transfer, sorted with one rank
// of compare-exchange cells over NUM_VALS cycles, then held on the output
// until the consumer takes it.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; aborts any vector in flight
//   bus   : sort_oet_stream_if.slave (in/out handshakes, data, busy, and
//           out_idx when SORT_INDEX_EN is defined)
// Parameters: NUM_VALS (>= 2), SIZE.
// Optional feature macro: SORT_INDEX_EN -- per-lane tags holding the input
// lane number travel with each value and appear on out_idx.
// Latency: out_valid is high NUM_VALS clocks after the accept edge; a new
// vector may be accepted on the same edge the previous one drains.
// ---------------------------------------------------------------------------
module sort_oet_stream
  import sort_pkg::*;
#(
  parameter int NUM_VALS = SORT_DEF_NUM_VALS,
  parameter int SIZE     = SORT_DEF_SIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  sort_oet_stream_if.slave bus
);

  localparam int PASS_W = idx_w(NUM_VALS);
  localparam int N_EVEN = NUM_VALS / 2;
  localparam int N_ODD  = (NUM_VALS - 1) / 2;
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_VALS - 1);
`ifdef SORT_INDEX_EN
  localparam int IDX_W  = idx_w(NUM_VALS);
`endif

  sort_state_e       state_reg, state_next;
  logic [PASS_W-1:0] pass_reg;
  logic              desc_reg;
  logic [SIZE-1:0]   lane_reg  [NUM_VALS];
  logic [SIZE-1:0]   even_lane [NUM_VALS];
  logic [SIZE-1:0]   odd_lane  [NUM_VALS];
`ifdef SORT_INDEX_EN
  logic [IDX_W-1:0]  tag_reg   [NUM_VALS];
  logic [IDX_W-1:0]  even_tag  [NUM_VALS];
  logic [IDX_W-1:0]  odd_tag   [NUM_VALS];
`endif

  logic accept;
  logic load;
  logic step;
  logic last_pass;

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  // in_ready in DONE depends on out_ready so a new vector can replace the
  // one draining on the same edge.
  assign bus.in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_reg == DONE);
  assign bus.busy      = (state_reg == SORT);
  assign last_pass     = (pass_reg == LAST_PASS);

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = SORT;
          load       = 1'b1;
        end
      end
      SORT: begin
        step = 1'b1;
        if (last_pass) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (accept) begin
          state_next = SORT;
          load       = 1'b1;
        end else if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Compare-exchange rank. Even phases pair (0,1),(2,3)...; odd phases pair
  // (1,2),(3,4)...; any lane without a partner in a phase keeps its value.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_EVEN; gi++) begin : g_even
    sort_cmp_swap #(
`ifdef SORT_INDEX_EN
      .IDX_W (IDX_W),
`endif
      .SIZE  (SIZE)
    ) u_cell (
      .a      (lane_reg[2*gi]),
      .b      (lane_reg[2*gi+1]),
`ifdef SORT_INDEX_EN
      .tag_a  (tag_reg[2*gi]),
      .tag_b  (tag_reg[2*gi+1]),
      .lo_tag (even_tag[2*gi]),
      .hi_tag (even_tag[2*gi+1]),
`endif
      .desc   (desc_reg),
      .lo     (even_lane[2*gi]),
      .hi     (even_lane[2*gi+1])
    );
  end

  for (genvar gi = 0; gi < N_ODD; gi++) begin : g_odd
    sort_cmp_swap #(
`ifdef SORT_INDEX_EN
      .IDX_W (IDX_W),
`endif
      .SIZE  (SIZE)
    ) u_cell (
      .a      (lane_reg[2*gi+1]),
      .b      (lane_reg[2*gi+2]),
`ifdef SORT_INDEX_EN
      .tag_a  (tag_reg[2*gi+1]),
      .tag_b  (tag_reg[2*gi+2]),
      .lo_tag (odd_tag[2*gi+1]),
      .hi_tag (odd_tag[2*gi+2]),
`endif
      .desc   (desc_reg),
      .lo     (odd_lane[2*gi+1]),
      .hi     (odd_lane[2*gi+2])
    );
  end

  // Lane 0 never takes part in an odd phase.
  assign odd_lane[0] = lane_reg[0];
`ifdef SORT_INDEX_EN
  assign odd_tag[0]  = tag_reg[0];
`endif

  // The top lane is unpaired in even phases for odd NUM_VALS and in odd
  // phases for even NUM_VALS.
  if ((NUM_VALS % 2) == 1) begin : g_hold_even_top
    assign even_lane[NUM_VALS-1] = lane_reg[NUM_VALS-1];
`ifdef SORT_INDEX_EN
    assign even_tag[NUM_VALS-1]  = tag_reg[NUM_VALS-1];
`endif
  end else begin : g_hold_odd_top
    assign odd_lane[NUM_VALS-1]  = lane_reg[NUM_VALS-1];
`ifdef SORT_INDEX_EN
    assign odd_tag[NUM_VALS-1]   = tag_reg[NUM_VALS-1];
`endif
  end

  // -------------------------------------------------------------------------
  // Working array, pass counter and order latch
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_reg <= '0;
      desc_reg <= 1'b0;
      for (int k = 0; k < NUM_VALS; k++) begin
        lane_reg[k] <= '0;
      end
    end else if (load) begin
      pass_reg <= '0;
      desc_reg <= bus.in_desc;
      for (int k = 0; k < NUM_VALS; k++) begin
        lane_reg[k] <= `SORT_LANE(bus.in_data, k, SIZE);
      end
    end else if (step) begin
      // Counter returns to zero after the final phase so it is clean in DONE.
      pass_reg <= last_pass ? '0 : pass_reg + PASS_W'(1);
      for (int k = 0; k < NUM_VALS; k++) begin
        lane_reg[k] <= pass_reg[0] ? odd_lane[k] : even_lane[k];
      end
    end
  end

`ifdef SORT_INDEX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_VALS; k++) begin
        tag_reg[k] <= '0;
      end
    end else if (load) begin
      for (int k = 0; k < NUM_VALS; k++) begin
        tag_reg[k] <= IDX_W'(k);
      end
    end else if (step) begin
      for (int k = 0; k < NUM_VALS; k++) begin
        tag_reg[k] <= pass_reg[0] ? odd_tag[k] : even_tag[k];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_VALS; gi++) begin : g_out_idx
    assign `SORT_LANE(bus.out_idx, gi, IDX_W) = tag_reg[gi];
  end
`endif

  for (genvar gi = 0; gi < NUM_VALS; gi++) begin : g_out_data
    assign `SORT_LANE(bus.out_data, gi, SIZE) = lane_reg[gi];
  end

endmodule

// File: tb/tb_sort_oet_stream.sv
// ---------------------------------------------------------------------------
// tb_sort_oet_stream
// Directed checks on a 4-lane instance (reset abort, descending, ascending
// with ties, back-pressure, back-to-back) and a randomized stream on a
// 9-lane instance against a stable insertion-sort reference.
// ---------------------------------------------------------------------------
module tb_sort_oet_stream;
  import sort_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sort_oet_stream_if #(.NUM_VALS(4), .SIZE(8)) bus4 ();
  sort_oet_stream_if #(.NUM_VALS(9), .SIZE(8)) bus9 ();

  sort_oet_stream #(.NUM_VALS(4), .SIZE(8)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  sort_oet_stream #(.NUM_VALS(9), .SIZE(8)) dut9 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus9.slave)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count clocks until out_valid; result is the index of the first edge at
  // which out_valid is sampled high, counting the accept edge as edge 0.
  task automatic wait_out4(output int lat);
    int cnt;
    cnt = 0;
    while (!bus4.out_valid && cnt < 40) begin
      tick();
      cnt++;
    end
    lat = cnt + 1;
  endtask

  function automatic logic [31:0] p4(input logic [7:0] a0, input logic [7:0] a1,
                                     input logic [7:0] a2, input logic [7:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [7:0] i4(input logic [1:0] a0, input logic [1:0] a1,
                                    input logic [1:0] a2, input logic [1:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  // Stable reference: insertion sort that only moves past strictly
  // out-of-order neighbours.
  function automatic void ref_sort9(input logic [71:0] din, input logic desc,
                                    output logic [71:0] dout, output logic [35:0] iout);
    logic [7:0] v [9];
    logic [3:0] t [9];
    logic [7:0] tv;
    logic [3:0] tt;
    int j;
    for (int k = 0; k < 9; k++) begin
      v[k] = din[k*8 +: 8];
      t[k] = 4'(k);
    end
    for (int i = 1; i < 9; i++) begin
      j = i;
      while (j > 0 && (desc ? (v[j] > v[j-1]) : (v[j] < v[j-1]))) begin
        tv = v[j]; v[j] = v[j-1]; v[j-1] = tv;
        tt = t[j]; t[j] = t[j-1]; t[j-1] = tt;
        j--;
      end
    end
    for (int k = 0; k < 9; k++) begin
      dout[k*8 +: 8] = v[k];
      iout[k*4 +: 4] = t[k];
    end
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [71:0] vdat, rd, e;
    logic [35:0] ri;
    logic        vdesc;
    logic [71:0] exp_q [$];
    logic [35:0] idx_q [$];
    int sent, got, cyc;
    bit pending;

    bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_desc = 1'b0; bus4.out_ready = 1'b0;
    bus9.in_valid = 1'b0; bus9.in_data = '0; bus9.in_desc = 1'b0; bus9.out_ready = 1'b0;

    // ---- reset state ----
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", bus4.out_valid, 1'b0);
    chk("rst_busy", bus4.busy, 1'b0);
    chk("rst_out_data", bus4.out_data, 32'h0);
    chk("rst_in_ready", bus4.in_ready, 1'b1);
    chk("rst9_out_valid", bus9.out_valid, 1'b0);
    rst_n = 1'b1;
    tick();

    // ---- 1: reset two cycles after accept ----
    bus4.in_valid = 1'b1; bus4.in_data = p4(3, 9, 1, 7); bus4.in_desc = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    chk("t1_busy_after_accept", bus4.busy, 1'b1);
    chk("t1_in_ready_in_sort", bus4.in_ready, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t1_abort_out_valid", bus4.out_valid, 1'b0);
    chk("t1_abort_busy", bus4.busy, 1'b0);
    chk("t1_abort_out_data", bus4.out_data, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t1_release_in_ready", bus4.in_ready, 1'b1);
    chk("t1_release_out_valid", bus4.out_valid, 1'b0);
    chk("t1_release_out_data", bus4.out_data, 32'h0);

    // ---- 2: descending, in_desc must be latched on accept ----
    bus4.out_ready = 1'b1;
    bus4.in_valid = 1'b1; bus4.in_data = p4(3, 9, 1, 7); bus4.in_desc = 1'b1;
    tick();
    bus4.in_valid = 1'b0; bus4.in_desc = 1'b0;
    wait_out4(lat);
    chk("t2_latency", lat, 5);
    chk("t2_data", bus4.out_data, p4(9, 7, 3, 1));
`ifdef SORT_INDEX_EN
    chk("t2_idx", bus4.out_idx, i4(1, 3, 0, 2));
`endif
    tick();
    chk("t2_drained_out_valid", bus4.out_valid, 1'b0);
    chk("t2_drained_in_ready", bus4.in_ready, 1'b1);

    // ---- 3/4: ascending with ties, then back-pressure ----
    bus4.out_ready = 1'b0;
    bus4.in_valid = 1'b1; bus4.in_data = p4(5, 2, 5, 2); bus4.in_desc = 1'b0;
    tick();
    bus4.in_valid = 1'b0;
    wait_out4(lat);
    chk("t3_latency", lat, 5);
    chk("t3_data", bus4.out_data, p4(2, 2, 5, 5));
`ifdef SORT_INDEX_EN
    chk("t3_idx", bus4.out_idx, i4(1, 3, 0, 2));
`endif
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t4_hold_valid", bus4.out_valid, 1'b1);
      chk("t4_hold_data", bus4.out_data, p4(2, 2, 5, 5));
      chk("t4_hold_in_ready", bus4.in_ready, 1'b0);
    end
    bus4.out_ready = 1'b1;
    #1;
    chk("t4_in_ready_with_out_ready", bus4.in_ready, 1'b1);
    tick();
    bus4.out_ready = 1'b0;
    chk("t4_after_take_valid", bus4.out_valid, 1'b0);
    chk("t4_after_take_busy", bus4.busy, 1'b0);
    tick();
    chk("t4_no_second_take", bus4.out_valid, 1'b0);

    // ---- 5: back-to-back accept on the draining edge ----
    bus4.in_valid = 1'b1; bus4.in_data = p4(3, 9, 1, 7); bus4.in_desc = 1'b0;
    tick();
    bus4.in_valid = 1'b0;
    wait_out4(lat);
    chk("t5_first_data", bus4.out_data, p4(1, 3, 7, 9));
    chk("t5_in_ready_stalled", bus4.in_ready, 1'b0);
    bus4.out_ready = 1'b1;
    bus4.in_valid = 1'b1; bus4.in_data = p4(0, 255, 128, 1); bus4.in_desc = 1'b1;
    #1;
    chk("t5_in_ready_drain", bus4.in_ready, 1'b1);
    tick();
    bus4.in_valid = 1'b0;
    chk("t5_busy_next", bus4.busy, 1'b1);
    chk("t5_out_valid_next", bus4.out_valid, 1'b0);
    wait_out4(lat);
    chk("t5_latency", lat, 5);
    chk("t5_second_data", bus4.out_data, p4(255, 128, 1, 0));
`ifdef SORT_INDEX_EN
    chk("t5_second_idx", bus4.out_idx, i4(1, 2, 3, 0));
`endif
    tick();
    bus4.out_ready = 1'b0;
    chk("t5_drained", bus4.out_valid, 1'b0);

    // ---- 6: 9-lane random stream with stalls ----
    sent = 0; got = 0; cyc = 0; pending = 1'b0;
    vdat = '0; vdesc = 1'b0;
    while (got < 1000 && cyc < 60000) begin
      bus9.out_ready = ($urandom_range(0, 3) != 0);
      if (!pending && sent < 1000) begin
        for (int k = 0; k < 9; k++) begin
          vdat[k*8 +: 8] = (sent % 2 == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
        end
        vdesc   = 1'($urandom_range(0, 1));
        pending = 1'b1;
      end
      bus9.in_valid = pending;
      bus9.in_data  = vdat;
      bus9.in_desc  = vdesc;
      #1;
      if (bus9.out_valid && bus9.out_ready) begin
        chk("t6_output_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("t6_data", bus9.out_data, e);
          ri = idx_q.pop_front();
`ifdef SORT_INDEX_EN
          chk("t6_idx", bus9.out_idx, ri);
`endif
        end
        got++;
      end
      if (bus9.in_valid && bus9.in_ready) begin
        ref_sort9(vdat, vdesc, rd, ri);
        exp_q.push_back(rd);
        idx_q.push_back(ri);
        sent++;
        pending = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus9.in_valid  = 1'b0;
    bus9.out_ready = 1'b0;
    chk("t6_sent", sent, 1000);
    chk("t6_received", got, 1000);
    chk("t6_leftover", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
